gray_counter_ctrl: RTL and testbench
====================================

Name: gray_counter_ctrl

Overview:
Parametrised Gray-code counter with enable, up/down direction, parallel load and a wrap/saturate mode.
- Outputs the count as a registered Gray code word plus its binary equivalent.
- Provides registered terminal flags and a one-cycle wrap pulse.
- Used wherever a multi-bit count crosses a clock domain or drives glitch-sensitive logic, e.g. FIFO pointers, position encoders and timer sequencers.

Parameters:
DATA_WIDTH, 4, counter width in bits (>= 2); count range 0 .. 2**DATA_WIDTH-1
SATURATE_DEFAULT, 0, value of the internal mode bit after reset (0 = wrap, 1 = saturate)

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  synchronous, active-low reset
en  input  1  count enable; one step per cycle while high
up_dn  input  1  direction: 1 = increment, 0 = decrement
load  input  1  parallel load strobe
load_gray  input  DATA_WIDTH  value to load, Gray-encoded
mode_wr  input  1  write strobe for the mode bit
mode_sat  input  1  mode value sampled when mode_wr=1
out  output  DATA_WIDTH  current count, Gray code, registered
bin_out  output  DATA_WIDTH  current count, binary, registered
at_max  output  1  registered; high when count == 2**DATA_WIDTH-1
at_min  output  1  registered; high when count == 0
wrap  output  1  registered one-cycle pulse on a wrap-around transition

Behaviour:
- State: binary count register cnt, mode bit sat, and registered outputs. Out is registered directly from the next Gray value, so no combinational path from cnt to out.
- Reset (resetn=0 at a clk edge):
  - cnt=0, out=0, bin_out=0, at_min=1, at_max=0, wrap=0.
  - sat=SATURATE_DEFAULT.
  - Reset overrides every other input.
- Priority per cycle: reset > load > en. mode_wr is independent and takes effect for the next cycle's step.
- Load (load=1):
  - cnt <= gray2bin(load_gray); out <= load_gray.
  - wrap=0; en and up_dn are ignored that cycle.
- Count (en=1, load=0), with MAX=2**DATA_WIDTH-1:
  - up_dn=1, cnt<MAX: cnt+1.
  - up_dn=1, cnt==MAX: wrap mode -> 0 with wrap=1 the following cycle; saturate mode -> hold at MAX, wrap=0.
  - up_dn=0, cnt>0: cnt-1.
  - up_dn=0, cnt==0: wrap mode -> MAX with wrap=1; saturate mode -> hold at 0, wrap=0.
- Hold (en=0, load=0): all state holds; wrap=0.
- Latency: a step or load requested in cycle N is visible on out/bin_out/at_max/at_min/wrap after edge N.
- Gray invariant: every count step changes exactly one bit of out, including MAX<->0 wrap. Load and reset are exempt.
- Arithmetic is modulo 2**DATA_WIDTH with no unsigned over/underflow leakage. bin_out always equals gray2bin(out).
- Encoding: bin2gray(b) = b ^ (b>>1). gray2bin: b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
- Direction change mid-count takes effect on the same cycle with no dead step.
- Reset asserted mid-count or during load clears all state regardless of other inputs.

Decomposition:
- Package gray_pkg:
  - mode enum: MODE_WRAP=0, MODE_SAT=1.
  - Parametrised functions bin2gray and gray2bin.
- One sub-module, gray2bin_conv (combinational, DATA_WIDTH parameter), used on the load path and reusable by synchroniser consumers.
- Counter and flag logic remain in gray_counter_ctrl.

Test Plan:
- Reset, then en=1, up_dn=1 for 16 cycles, wrap mode, W=4 -> out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. wrap=1 only on the cycle out returns to 0. Exactly one bit changes per step.
- Load load_gray=0xF, then hold -> out=0xF, bin_out=0xA, at_max=0, at_min=0.
- Saturate mode: mode_wr=1/mode_sat=1, load 0x8 (bin 15), en=1, up_dn=1 for 3 cycles -> out stays 0x8, at_max=1, wrap never set. Then up_dn=0 -> out=0x9 (bin 14).
- Wrap mode down from 0: reset, en=1, up_dn=0 -> out=0x8, bin_out=0xF, wrap pulses once, at_max=1.
- Simultaneous load=1 and en=1 with load_gray=0x6 -> out=0x6 (bin 4), no extra step. resetn=0 with load=1 the next cycle -> out=0.
- en toggled randomly with up_dn changes over 200 cycles -> bin_out tracks a reference model. bin_out==gray2bin(out) every cycle.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter slice.
//   mode_e      : counter end-of-range behaviour (wrap or saturate)
//   bin2gray    : binary -> Gray conversion
//   gray2bin    : Gray -> binary conversion
// The conversion functions operate on a GRAY_MAX_W-bit word. Callers
// zero-extend narrower values in and truncate the result back out; this is
// exact because the leading zero bits of a zero-extended word never disturb
// the lower bits in either direction.
package gray_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_ctrl_if.sv
// Control/status bundle of the Gray-code counter.
//   master : drives the command inputs, observes the count and flags
//   slave  : the counter itself
// Signals:
//   en, up_dn           step enable and direction (1 = up)
//   load, load_gray     parallel load strobe and Gray-encoded load value
//   mode_wr, mode_sat   mode register write strobe and value (1 = saturate)
//   out, bin_out        registered count, Gray and binary
//   at_max, at_min      registered terminal flags
//   wrap                registered one-cycle wrap-around pulse
interface gray_counter_ctrl_if #(
  parameter int DATA_WIDTH = 4
);

  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_gray;
  logic                  mode_wr;
  logic                  mode_sat;
  logic [DATA_WIDTH-1:0] out;
  logic [DATA_WIDTH-1:0] bin_out;
  logic                  at_max;
  logic                  at_min;
  logic                  wrap;

  modport master (
    output en, up_dn, load, load_gray, mode_wr, mode_sat,
    input  out, bin_out, at_max, at_min, wrap
  );

  modport slave (
    input  en, up_dn, load, load_gray, mode_wr, mode_sat,
    output out, bin_out, at_max, at_min, wrap
  );

endinterface

// File: rtl/gray2bin_conv.sv
// Combinational Gray -> binary converter.
//   gray : Gray-encoded input word
//   bin  : binary equivalent
// Each binary bit is the XOR of all Gray bits at or above its position,
// which avoids a ripple written back through the output vector.
module gray2bin_conv #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] gray,
  output logic [DATA_WIDTH-1:0] bin
);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[DATA_WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter_ctrl.sv
// Gray-code up/down counter with enable, parallel load and wrap/saturate mode.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset, overrides every other input
//   bus     gray_counter_ctrl_if slave: commands in, count and flags out
// Priority per cycle: reset > load > en. A mode write lands in the mode
// register at the edge, so the step taken in the same cycle still uses the
// previous mode.
// DATA_WIDTH must be in 2 .. GRAY_MAX_W.
module gray_counter_ctrl
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH       = 4,
  parameter bit SATURATE_DEFAULT = 1'b0
) (
  input logic             clk,
  input logic             resetn,
  gray_counter_ctrl_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] MAX_CNT = '1;

  logic [DATA_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] cnt_nxt;
  logic [DATA_WIDTH-1:0] out_nxt;
  logic [DATA_WIDTH-1:0] load_bin;
  logic                  wrap_nxt;
  mode_e                 sat;

  gray2bin_conv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_conv (
    .gray(bus.load_gray),
    .bin (load_bin)
  );

  // One count step. Returns {wrap, next_count}; at either end of the range
  // the mode decides between holding and wrapping with a pulse.
  function automatic logic [DATA_WIDTH:0] step_cnt(
    input logic [DATA_WIDTH-1:0] c,
    input logic                  up,
    input mode_e                 m
  );
    if (up) begin
      if (c == MAX_CNT) begin
        return (m == MODE_SAT) ? {1'b0, c} : {1'b1, {DATA_WIDTH{1'b0}}};
      end
      return {1'b0, c + 1'b1};
    end
    if (c == '0) begin
      return (m == MODE_SAT) ? {1'b0, c} : {1'b1, MAX_CNT};
    end
    return {1'b0, c - 1'b1};
  endfunction

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    out_nxt  = DATA_WIDTH'(bin2gray(GRAY_MAX_W'(cnt)));
    if (bus.load) begin
      cnt_nxt = load_bin;
      out_nxt = bus.load_gray;
    end else if (bus.en) begin
      {wrap_nxt, cnt_nxt} = step_cnt(cnt, bus.up_dn, sat);
      out_nxt             = DATA_WIDTH'(bin2gray(GRAY_MAX_W'(cnt_nxt)));
    end
  end

  // Registered outputs: out, flags and wrap are all taken from next-state
  // values so nothing downstream sees a combinational decode of cnt.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt        <= '0;
      bus.out    <= '0;
      bus.at_max <= 1'b0;
      bus.at_min <= 1'b1;
      bus.wrap   <= 1'b0;
      sat        <= mode_e'(SATURATE_DEFAULT);
    end else begin
      cnt        <= cnt_nxt;
      bus.out    <= out_nxt;
      bus.at_max <= (cnt_nxt == MAX_CNT);
      bus.at_min <= (cnt_nxt == '0);
      bus.wrap   <= wrap_nxt;
      if (bus.mode_wr) begin
        sat <= mode_e'(bus.mode_sat);
      end
    end
  end

  assign bus.bin_out = cnt;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Self-checking bench for gray_counter_ctrl (DATA_WIDTH = 4, wrap by default).
// The reference keeps the count as a plain integer and applies the counting
// rules arithmetically; Gray values are derived from it, and Gray -> binary
// is found by searching for the integer whose Gray code matches.
module tb_gray_counter_ctrl;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic resetn;

  gray_counter_ctrl_if #(.DATA_WIDTH(W)) bus ();

  gray_counter_ctrl #(
    .DATA_WIDTH      (W),
    .SATURATE_DEFAULT(1'b0)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int m_cnt   = 0;
  bit m_sat   = 1'b0;
  bit m_wrap  = 1'b0;
  bit m_step  = 1'b0;
  bit m_valid = 1'b0;

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int bin_of(int g);
    for (int b = 0; b <= MAXV; b++) begin
      if (gray_of(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the reference at the edge, and
  // return at the following falling edge.
  task automatic step(input bit rn, input bit e, input bit u, input bit ld,
                      input int lg, input bit mw, input bit ms);
    resetn        = rn;
    bus.en        = e;
    bus.up_dn     = u;
    bus.load      = ld;
    bus.load_gray = W'(lg);
    bus.mode_wr   = mw;
    bus.mode_sat  = ms;
    @(posedge clk);
    m_step = 1'b0;
    if (!rn) begin
      m_cnt  = 0;
      m_sat  = 1'b0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (ld) begin
        m_cnt = bin_of(lg & MAXV);
      end else if (e) begin
        if (u) begin
          if (m_cnt < MAXV) begin
            m_cnt++;
            m_step = 1'b1;
          end else if (!m_sat) begin
            m_cnt  = 0;
            m_wrap = 1'b1;
            m_step = 1'b1;
          end
        end else begin
          if (m_cnt > 0) begin
            m_cnt--;
            m_step = 1'b1;
          end else if (!m_sat) begin
            m_cnt  = MAXV;
            m_wrap = 1'b1;
            m_step = 1'b1;
          end
        end
      end
      if (mw) m_sat = ms;
    end
    m_valid = 1'b1;
    @(negedge clk);
  endtask

  // Per-cycle comparison against the reference
  logic [W-1:0] prev_out = '0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("out",     bus.out,     gray_of(m_cnt));
      check("bin_out", bus.bin_out, m_cnt);
      check("at_max",  bus.at_max,  (m_cnt == MAXV));
      check("at_min",  bus.at_min,  (m_cnt == 0));
      check("wrap",    bus.wrap,    m_wrap);
      check("bin_is_g2b", bus.bin_out, bin_of(int'(bus.out)));
      if (m_step) check("one_bit_step", $countones(bus.out ^ prev_out), 1);
      prev_out = bus.out;
    end
  end

  logic [3:0] seq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    resetn        = 1'b0;
    bus.en        = 1'b0;
    bus.up_dn     = 1'b0;
    bus.load      = 1'b0;
    bus.load_gray = '0;
    bus.mode_wr   = 1'b0;
    bus.mode_sat  = 1'b0;
    @(negedge clk);

    // Reset state, with other inputs active to show reset wins
    step(0, 1, 1, 1, 5, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_out",    bus.out, 4'h0);
    check("rst_at_min", bus.at_min, 1'b1);
    check("rst_at_max", bus.at_max, 1'b0);

    // Full up-count cycle in wrap mode
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, 1, 0, 0, 0, 0);
      check("seq_out",  bus.out, seq[i]);
      check("seq_wrap", bus.wrap, (i == 16));
    end

    // Load 0xF then hold
    step(1, 0, 0, 1, 'hF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("ld_out",    bus.out, 4'hF);
    check("ld_bin",    bus.bin_out, 4'hA);
    check("ld_at_max", bus.at_max, 1'b0);
    check("ld_at_min", bus.at_min, 1'b0);

    // Saturate mode at the top
    step(1, 0, 0, 1, 'h8, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0, 0, 0);
      check("sat_out",    bus.out, 4'h8);
      check("sat_at_max", bus.at_max, 1'b1);
      check("sat_wrap",   bus.wrap, 1'b0);
    end
    step(1, 1, 0, 0, 0, 0, 0);
    check("sat_dn_out", bus.out, 4'h9);
    check("sat_dn_bin", bus.bin_out, 4'hE);

    // Reset restores wrap mode; down-count from zero wraps to max
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    check("dn_wrap_out",    bus.out, 4'h8);
    check("dn_wrap_bin",    bus.bin_out, 4'hF);
    check("dn_wrap_pulse",  bus.wrap, 1'b1);
    check("dn_wrap_at_max", bus.at_max, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0);
    check("dn_wrap_clear",  bus.wrap, 1'b0);

    // Load beats enable; reset beats load
    step(1, 1, 1, 1, 'h6, 0, 0);
    check("ld_en_out", bus.out, 4'h6);
    check("ld_en_bin", bus.bin_out, 4'h4);
    step(0, 1, 1, 1, 'h3, 0, 0);
    check("rst_ld_out", bus.out, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 49) != 0),
           $urandom_range(0, 1),
           $urandom_range(0, 1),
           ($urandom_range(0, 15) == 0),
           $urandom_range(0, MAXV),
           ($urandom_range(0, 19) == 0),
           $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
